td4x_core: RTL and testbench
============================

# td4x_core

Parametrised successor to the 4-bit TD4 CPU core. It keeps the TD4 instruction set: registers A/B, 1-bit carry flag, input and output ports, ADD/MOV/IN/OUT/JMP/JNC. Data width and address width become generic. Instruction fetch becomes a req/ack handshake, so program memory may insert wait states. The block adds a HALT instruction and an output strobe. It sits between the program ROM/RAM wrapper and the board-level I/O pins.

## Interface
Parameters:
- DW, 4, data/immediate width (4..8); instruction width IW = 4 + DW
- AW, 4, program-counter/address width (2..8)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  fetch request; high exactly while in FETCH
- imem_addr  out  AW  fetch address; equals PC
- imem_ack  in  1  fetch data valid this cycle; sampled only while imem_req=1
- imem_data  in  IW  instruction; [IW-1:IW-4] = opcode, [DW-1:0] = Im
- port_i  in  DW  input port
- port_o  out  DW  output port register
- port_o_stb  out  1  one-cycle pulse after port_o is written
- cf  out  1  carry flag
- halted  out  1  core stopped by HALT

## Operation
- State machine: FETCH, EXEC, HALT.
- Reset enters FETCH with PC=0, A=0, B=0, port_o=0, cf=0, port_o_stb=0, halted=0, IR=0.
- **FETCH**
  - imem_req=1 and imem_addr=PC.
  - On the edge where imem_ack=1, latch imem_data into IR and go to EXEC.
  - Otherwise hold; PC and imem_addr stay stable.
- **EXEC** (one cycle): decode IR, then apply on the closing edge:
  - 0000 ADD A,Im: A <= A+Im
  - 0101 ADD B,Im: B <= B+Im
  - 0011 MOV A,Im: A <= Im
  - 0111 MOV B,Im: B <= Im
  - 0001 MOV A,B: A <= B+Im (Im normally 0)
  - 0100 MOV B,A: B <= A+Im
  - 0010 IN A: A <= port_i+Im
  - 0110 IN B: B <= port_i+Im
  - 1001 OUT B: port_o <= B+Im
  - 1011 OUT Im: port_o <= Im
  - 1111 JMP Im: PC <= Im
  - 1110 JNC Im: PC <= Im if cf==0 before this edge, else PC+1
  - 1100 HALT: go to HALT, halted <= 1, PC unchanged
  - 1000, 1010, 1101: NOP; no register or cf change; PC+1
- Datapath rules:
  - Single DW-bit adder. The operand is A, B, port_i or 0, selected by opcode; the other input is Im; carry-in is 0.
  - For every ADD/MOV/IN/OUT/JMP/JNC, cf <= adder carry-out. MOV/JMP/JNC with operand 0 always clear cf.
  - Sums wrap modulo 2^DW.
  - The PC target is Im, truncated or zero-extended to AW.
  - PC+1 wraps from 2^AW-1 to 0.
  - Non-jump instructions use PC <= PC+1.
- After EXEC, return to FETCH (except HALT).
- HALT: imem_req=0; all state frozen until rst.

## Timing
- Minimum 2 cycles per instruction (ack in the first FETCH cycle). Each ack wait state adds 1 cycle.
- IR is loaded only from a FETCH cycle with req&ack. imem_ack in EXEC or HALT is ignored.
- port_i is sampled combinationally during the EXEC cycle.
- A, B, cf, PC and port_o update on the EXEC→FETCH edge.
- port_o_stb is registered: high for exactly the one cycle after an OUT's EXEC edge, including when the value is unchanged. It is 0 otherwise.
- JNC tests cf as produced by the previous executed instruction.
- rst asserted in any state, including mid-fetch with ack pending: all outputs reach reset values immediately, without waiting for clk.
- After rst deasserts, imem_req=1 with imem_addr=0 in the first cycle.

## Test plan
- **Reset:** assert rst mid-FETCH while imem_ack=1 → PC=0, port_o=0, cf=0, halted=0 immediately. After release, imem_req=1, imem_addr=0.
- **ADD carry (DW=4):** MOV A,0xF; ADD A,1; JNC 7 → A=0, cf=1, JNC not taken, PC=3. Then MOV A,0 (cf=0); JNC 7 → PC=7.
- **Wait states:** ack delayed 3 cycles on every fetch → imem_addr stable during the wait. Each instruction takes 5 cycles; results match the zero-wait run.
- **Output strobe:** MOV B,5; OUT B; OUT Im 5 → port_o=5 after each OUT. port_o_stb pulses twice, 1 cycle each.
- **PC wrap and jump truncation (AW=4, DW=8):** NOPs to address 15 → next fetch at 0. JMP 0x13 → PC=3.
- **HALT:** HALT at address 2 → halted=1, imem_req=0, PC=2 held for 20 cycles. rst then restarts from 0.

Source files
------------

// File: rtl/td4x_core.sv
// td4x_core: parametrised TD4-compatible CPU core.
//   Registers A/B, 1-bit carry flag and an output port register, all driven
//   through a single DW-bit adder (operand + Im, carry-in 0).
//   The instruction fetch is a req/ack handshake, so program memory may stall.
//   HALT stops the core until reset.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   imem_req    fetch request, high only while fetching
//   imem_addr   fetch address (PC)
//   imem_ack    fetch data valid; sampled only while imem_req is high
//   imem_data   instruction: [IW-1:IW-4] opcode, [DW-1:0] immediate
//   port_i      input port, read combinationally during execute
//   port_o      output port register
//   port_o_stb  one-cycle pulse after every OUT instruction
//   cf          carry flag
//   halted      core stopped by HALT
module td4x_core #(
  parameter int DW = 4,
  parameter int AW = 4,
  localparam int IW = 4 + DW
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_data,
  input  logic [DW-1:0] port_i,
  output logic [DW-1:0] port_o,
  output logic          port_o_stb,
  output logic          cf,
  output logic          halted
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_e;

  typedef enum logic [3:0] {
    OP_ADD_A  = 4'b0000,
    OP_MOV_AB = 4'b0001,
    OP_IN_A   = 4'b0010,
    OP_MOV_A  = 4'b0011,
    OP_MOV_BA = 4'b0100,
    OP_ADD_B  = 4'b0101,
    OP_IN_B   = 4'b0110,
    OP_MOV_B  = 4'b0111,
    OP_OUT_B  = 4'b1001,
    OP_OUT_IM = 4'b1011,
    OP_HALT   = 4'b1100,
    OP_JNC    = 4'b1110,
    OP_JMP    = 4'b1111
  } opcode_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] out_q, out_d;
  logic          cf_q, cf_d;
  logic          stb_q, stb_d;
  logic [IW-1:0] ir_q, ir_d;

  opcode_e       op;
  logic [DW-1:0] im;
  logic [DW-1:0] opnd;
  logic [DW-1:0] sum;
  logic          carry;
  logic [AW-1:0] jmp_tgt;

  assign op = opcode_e'(ir_q[IW-1:IW-4]);
  assign im = ir_q[DW-1:0];

  // Jump target is the immediate truncated or zero-extended to the PC width.
  if (AW <= DW) begin : g_tgt_trunc
    assign jmp_tgt = im[AW-1:0];
  end else begin : g_tgt_ext
    assign jmp_tgt = {{(AW - DW){1'b0}}, im};
  end

  // Adder operand; MOV-immediate, OUT Im and jumps add Im to zero.
  always_comb begin
    opnd = '0;
    case (op)
      OP_ADD_A, OP_MOV_BA:           opnd = a_q;
      OP_ADD_B, OP_MOV_AB, OP_OUT_B: opnd = b_q;
      OP_IN_A, OP_IN_B:              opnd = port_i;
      default:                       opnd = '0;
    endcase
  end

  assign {carry, sum} = {1'b0, opnd} + {1'b0, im};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    cf_d    = cf_q;
    stb_d   = 1'b0;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_q + AW'(1);
        cf_d    = carry;
        case (op)
          OP_ADD_A, OP_MOV_A, OP_MOV_AB, OP_IN_A: a_d = sum;
          OP_ADD_B, OP_MOV_B, OP_MOV_BA, OP_IN_B: b_d = sum;
          OP_OUT_B, OP_OUT_IM: begin
            out_d = sum;
            stb_d = 1'b1;
          end
          OP_JMP: pc_d = jmp_tgt;
          OP_JNC: if (!cf_q) pc_d = jmp_tgt;
          OP_HALT: begin
            state_d = S_HALT;
            pc_d    = pc_q;
            cf_d    = cf_q;
          end
          default: cf_d = cf_q;
        endcase
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      cf_q    <= 1'b0;
      stb_q   <= 1'b0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      cf_q    <= cf_d;
      stb_q   <= stb_d;
      ir_q    <= ir_d;
    end
  end

  assign imem_req   = (state_q == S_FETCH);
  assign imem_addr  = pc_q;
  assign port_o     = out_q;
  assign port_o_stb = stb_q;
  assign cf         = cf_q;
  assign halted     = (state_q == S_HALT);

endmodule

// File: tb/tb_td4x_core.sv
// Bench for td4x_core: two instances (DW=4/AW=4 and DW=8/AW=4) run side by
// side, each with its own program table, against an instruction-level model.
module tb_td4x_core;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       req4, ack4, stb4, cf4, halt4;
  logic [3:0] addr4, pi4, po4;
  logic [7:0] data4;
  logic       req8, ack8, stb8, cf8, halt8;
  logic [3:0] addr8;
  logic [7:0] pi8, po8;
  logic [11:0] data8;

  int  prog[2][16];
  int  pin;
  int  wait_n;
  bit  ack_r[2];
  bit  ack_force;
  int  checks = 0;
  int  errors = 0;

  assign ack4  = ack_force | ack_r[0];
  assign ack8  = ack_force | ack_r[1];
  assign data4 = 8'(prog[0][addr4]);
  assign data8 = 12'(prog[1][addr8]);
  assign pi4   = 4'(pin);
  assign pi8   = 8'(pin);

  td4x_core #(.DW(4), .AW(4)) dut4 (
    .clk(clk), .rst(rst), .imem_req(req4), .imem_addr(addr4),
    .imem_ack(ack4), .imem_data(data4), .port_i(pi4), .port_o(po4),
    .port_o_stb(stb4), .cf(cf4), .halted(halt4));

  td4x_core #(.DW(8), .AW(4)) dut8 (
    .clk(clk), .rst(rst), .imem_req(req8), .imem_addr(addr8),
    .imem_ack(ack8), .imem_data(data8), .port_i(pi8), .port_o(po8),
    .port_o_stb(stb8), .cf(cf8), .halted(halt8));

  // Model: st 0 = waiting for an instruction, 1 = instruction held, 2 = stopped.
  typedef struct {
    int st; int pc; int a; int b; int po; int cf; int stb; int ir; int cnt;
  } mdl_t;
  mdl_t m[2];

  function automatic mdl_t step(mdl_t cur, logic ack, int k);
    mdl_t n    = cur;
    int   lim  = (k == 0) ? 16 : 256;
    int   op   = cur.ir / lim;
    int   im   = cur.ir % lim;
    int   pv   = pin % lim;
    int   s    = im;
    bit   upd  = 1'b1;
    n.stb = 0;
    n.cnt = 0;
    if (cur.st == 0) begin
      if (ack) begin
        n.ir = prog[k][cur.pc];
        n.st = 1;
      end else begin
        n.cnt = cur.cnt + 1;
      end
    end else if (cur.st == 1) begin
      n.st = 0;
      n.pc = (cur.pc + 1) % 16;
      case (op)
        0:  begin s = cur.a + im; n.a = s % lim; end
        5:  begin s = cur.b + im; n.b = s % lim; end
        3:  n.a = im;
        7:  n.b = im;
        1:  begin s = cur.b + im; n.a = s % lim; end
        4:  begin s = cur.a + im; n.b = s % lim; end
        2:  begin s = pv + im;    n.a = s % lim; end
        6:  begin s = pv + im;    n.b = s % lim; end
        9:  begin s = cur.b + im; n.po = s % lim; n.stb = 1; end
        11: begin n.po = im; n.stb = 1; end
        15: n.pc = im % 16;
        14: if (cur.cf == 0) n.pc = im % 16;
        12: begin n.st = 2; n.pc = cur.pc; upd = 1'b0; end
        default: upd = 1'b0;
      endcase
      if (upd) n.cf = (s >= lim) ? 1 : 0;
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m[0] <= '{default: 0};
      m[1] <= '{default: 0};
    end else begin
      m[0] <= step(m[0], ack4, 0);
      m[1] <= step(m[1], ack8, 1);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, then ack for the next edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("req4",  req4,  m[0].st == 0);
      chk("addr4", addr4, m[0].pc);
      chk("po4",   po4,   m[0].po);
      chk("stb4",  stb4,  m[0].stb);
      chk("cf4",   cf4,   m[0].cf);
      chk("halt4", halt4, m[0].st == 2);
      chk("req8",  req8,  m[1].st == 0);
      chk("addr8", addr8, m[1].pc);
      chk("po8",   po8,   m[1].po);
      chk("stb8",  stb8,  m[1].stb);
      chk("cf8",   cf8,   m[1].cf);
      chk("halt8", halt8, m[1].st == 2);
      for (int k = 0; k < 2; k++)
        ack_r[k] = (m[k].st == 0) && (m[k].cnt >= wait_n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  task automatic fill(input int k, input int v);
    for (int i = 0; i < 16; i++) prog[k][i] = v;
  endtask

  int pulses;

  initial begin
    ack_force = 1'b0;
    ack_r[0]  = 1'b0;
    ack_r[1]  = 1'b0;
    pin       = 0;

    // Carry/JNC (DW=4) and PC wrap / jump truncation (DW=8).
    fill(0, 8'h80);
    prog[0][0] = 8'h3F; prog[0][1] = 8'h01; prog[0][2] = 8'hE7;
    prog[0][3] = 8'h40; prog[0][4] = 8'h95; prog[0][5] = 8'h30;
    prog[0][6] = 8'hE9; prog[0][9] = 8'hC0;
    fill(1, 12'h800);
    prog[1][0]  = 12'hE1E; prog[1][14] = 12'h3FF; prog[1][15] = 12'h001;
    prog[1][1]  = 12'hF13; prog[1][3]  = 12'hBA5; prog[1][4]  = 12'hC00;
    for (int pass = 0; pass < 2; pass++) begin
      wait_n = (pass == 0) ? 0 : 3;
      do_reset();
      chk("lit_rel_req4", req4, 1'b1);
      chk("lit_rel_addr4", addr4, 4'd0);
      if (pass == 0) begin
        cyc(4);
        chk("lit_add_cf4", cf4, 1'b1);
        chk("lit_add_addr4", addr4, 4'd2);
        cyc(2);
        chk("lit_jnc_nt_addr4", addr4, 4'd3);
        chk("lit_jnc_cf4", cf4, 1'b0);
        chk("lit_wrap_addr8", addr8, 4'd0);
        chk("lit_wrap_cf8", cf8, 1'b1);
        cyc(4);
        chk("lit_out_po4", po4, 4'd5);
        chk("lit_out_stb4", stb4, 1'b1);
        chk("lit_trunc_addr8", addr8, 4'd3);
        cyc(1);
        chk("lit_stb4_low", stb4, 1'b0);
        cyc(1);
        chk("lit_out_po8", po8, 8'hA5);
        chk("lit_out_stb8", stb8, 1'b1);
        cyc(10);
      end else begin
        cyc(10);
        chk("lit_ws_cf4", cf4, 1'b1);
        chk("lit_ws_addr4", addr4, 4'd2);
        cyc(5);
        chk("lit_ws_jnc_addr4", addr4, 4'd3);
        chk("lit_ws_wrap_addr8", addr8, 4'd0);
        cyc(1);
        chk("lit_ws_hold_addr4", addr4, 4'd3);
        chk("lit_ws_hold_req4", req4, 1'b1);
        cyc(60);
      end
      chk("lit_jnc_t_addr4", addr4, 4'd9);
      chk("lit_halt4", halt4, 1'b1);
      chk("lit_halt_req4", req4, 1'b0);
      chk("lit_final_po4", po4, 4'd5);
      chk("lit_halt8", halt8, 1'b1);
      chk("lit_halt_addr8", addr8, 4'd4);
    end

    // Output strobe (DW=4) and IN/MOV B,A/OUT B path (DW=8), one wait state.
    wait_n = 1;
    pin    = 8'h3C;
    fill(0, 8'h80);
    prog[0][0] = 8'h75; prog[0][1] = 8'h90; prog[0][2] = 8'hB5;
    prog[0][3] = 8'hA0; prog[0][4] = 8'hD0; prog[0][5] = 8'hC0;
    fill(1, 12'h800);
    prog[1][0] = 12'h200; prog[1][1] = 12'h401; prog[1][2] = 12'h900;
    prog[1][3] = 12'h610; prog[1][4] = 12'h900; prog[1][5] = 12'hC00;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      if (stb4) pulses++;
    end
    chk("lit_stb_pulses4", pulses, 2);
    chk("lit_stb_po4", po4, 4'd5);
    chk("lit_in_po8", po8, 8'h4C);
    chk("lit_halt_addr4", addr4, 4'd5);

    // HALT hold with ack ignored, then restart and an async reset mid-fetch.
    wait_n = 0;
    fill(0, 8'h80);
    prog[0][1] = 8'h33; prog[0][2] = 8'hC0;
    fill(1, 12'h800);
    prog[1][0] = 12'hB77; prog[1][1] = 12'h3FF; prog[1][2] = 12'h001;
    prog[1][3] = 12'hC00;
    do_reset();
    cyc(10);
    ack_force = 1'b1;
    cyc(10);
    ack_force = 1'b0;
    cyc(6);
    chk("lit_hold_halt4", halt4, 1'b1);
    chk("lit_hold_addr4", addr4, 4'd2);
    chk("lit_hold_req4", req4, 1'b0);
    chk("lit_hold_addr8", addr8, 4'd3);
    do_reset();
    chk("lit_restart_addr4", addr4, 4'd0);
    chk("lit_restart_req4", req4, 1'b1);
    chk("lit_restart_halt4", halt4, 1'b0);
    cyc(6);
    chk("lit_pre_cf8", cf8, 1'b1);
    chk("lit_pre_po8", po8, 8'h77);
    chk("lit_pre_req8", req8, 1'b1);
    #1 ack_force = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("lit_arst_addr8", addr8, 4'd0);
    chk("lit_arst_po8", po8, 8'h00);
    chk("lit_arst_cf8", cf8, 1'b0);
    chk("lit_arst_req8", req8, 1'b1);
    chk("lit_arst_halt4", halt4, 1'b0);
    chk("lit_arst_addr4", addr4, 4'd0);
    cyc(1);
    ack_force = 1'b0;
    rst = 1'b0;
    cyc(2);
    chk("lit_after_addr4", addr4, 4'd1);
    chk("lit_after_addr8", addr8, 4'd1);
    chk("lit_after_po8", po8, 8'h77);
    cyc(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
